addr_sequencer: RTL

//  Parametrised instruction-memory address sequencer for the lab processor top level.

---
 rtl/addr_sequencer_if.sv | 26 ++
 rtl/addr_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/addr_sequencer_if.sv
// Control/status bundle between the lab processor top level and the address sequencer.
// The master side drives the key, mode and load controls; the slave side returns the address and status.
interface addr_sequencer_if #(
  parameter int AW = 5
);
  logic          Key_n;
  logic          Run;
  logic          Dir;
  logic          WrapEn;
  logic          Load;
  logic [AW-1:0] LoadAddr;
  logic [AW-1:0] Addr;
  logic          Adv;
  logic          Wrapped;
  logic          Done;

  modport master (
    output Key_n, Run, Dir, WrapEn, Load, LoadAddr,
    input  Addr, Adv, Wrapped, Done
  );

  modport slave (
    input  Key_n, Run, Dir, WrapEn, Load, LoadAddr,
    output Addr, Adv, Wrapped, Done
  );
endinterface

// File: rtl/addr_sequencer.sv
// Instruction-memory address sequencer: a debounced key or a prescaled tick advances the address.
// Counting can go up or down, and it can wrap or stop at the end. A synchronous load overrides advancing.
module addr_sequencer #(
  parameter int AW        = 5,
  parameter int DEPTH     = 32,
  parameter int TICK_DIV  = 4,
  parameter int DB_CYCLES = 3
) (
  input logic            Clock,
  input logic            Resetn,
  addr_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {REL, PRESS_CHK, PRESSED, REL_CHK} db_state_t;

  logic          key_p0, key_p1;
  db_state_t     db_state;
  logic [CW-1:0] db_cnt;
  logic          press_p2;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          adv_req;
  logic [AW-1:0] addr_q;
  logic          adv_q, wrapped_q, done_q;

  function automatic logic [AW-1:0] clamp_addr(input logic [AW-1:0] a);
    return (a > LAST) ? LAST : a;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous key
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= bus.Key_n;
      key_p1 <= key_p0;
    end
  end

  // Stage p2: debounce FSM, one press pulse per stable press
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      db_state <= REL;
      db_cnt   <= '0;
      press_p2 <= 1'b0;
    end else begin
      press_p2 <= 1'b0;
      case (db_state)
        REL: if (!key_p1) begin
          if (DB_CYCLES == 1) begin
            db_state <= PRESSED;
            press_p2 <= 1'b1;
          end else begin
            db_state <= PRESS_CHK;
            db_cnt   <= CW'(1);
          end
        end
        PRESS_CHK: begin
          if (key_p1) db_state <= REL;
          else if (db_cnt == DB_LAST) begin
            db_state <= PRESSED;
            press_p2 <= 1'b1;
          end else db_cnt <= db_cnt + 1'b1;
        end
        PRESSED: if (key_p1) begin
          if (DB_CYCLES == 1) db_state <= REL;
          else begin
            db_state <= REL_CHK;
            db_cnt   <= CW'(1);
          end
        end
        REL_CHK: begin
          if (!key_p1) db_state <= PRESSED;
          else if (db_cnt == DB_LAST) db_state <= REL;
          else db_cnt <= db_cnt + 1'b1;
        end
        default: db_state <= REL;
      endcase
    end
  end

  // Prescaler holds while Done so it resumes where it stopped after a load
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) pre_cnt <= '0;
    else if (!bus.Run) pre_cnt <= '0;
    else if (!done_q) pre_cnt <= (pre_cnt == TICK_LAST) ? '0 : pre_cnt + 1'b1;
  end

  assign tick    = bus.Run && !done_q && (pre_cnt == TICK_LAST);
  assign adv_req = bus.Run ? tick : press_p2;

  // Address register: load has priority; wrapping is explicit at DEPTH-1, not modulo 2**AW
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_q    <= '0;
      adv_q     <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      adv_q     <= 1'b0;
      wrapped_q <= 1'b0;
      if (bus.Load) begin
        addr_q <= clamp_addr(bus.LoadAddr);
        done_q <= 1'b0;
      end else if (adv_req && !done_q) begin
        if (bus.Dir ? (addr_q < LAST) : (addr_q != '0)) begin
          addr_q <= bus.Dir ? addr_q + 1'b1 : addr_q - 1'b1;
          adv_q  <= 1'b1;
        end else if (bus.WrapEn) begin
          addr_q    <= bus.Dir ? '0 : LAST;
          adv_q     <= 1'b1;
          wrapped_q <= 1'b1;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.Addr    = addr_q;
  assign bus.Adv     = adv_q;
  assign bus.Wrapped = wrapped_q;
  assign bus.Done    = done_q;

endmodule
